// File: rtl/tune_sched_if.sv
// rtl/tune_sched_if.sv - request/go bundle between cmd_proc, tune_scheduler and charge
// TUNE_SCHED_FLUSH_EN adds the flush request line.
interface tune_sched_if #(parameter int PEND_W = 3);
  logic              req;
  logic              ovf_clr;
`ifdef TUNE_SCHED_FLUSH_EN
  logic              flush;
`endif
  logic              go;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

`ifdef TUNE_SCHED_FLUSH_EN
  modport master (output req, ovf_clr, flush, input go, busy, pending, overflow);
  modport slave  (input req, ovf_clr, flush, output go, busy, pending, overflow);
`else
  modport master (output req, ovf_clr, input go, busy, pending, overflow);
  modport slave  (input req, ovf_clr, output go, busy, pending, overflow);
`endif
endinterface

// File: rtl/tune_scheduler.sv
// rtl/tune_scheduler.sv - queues fanfare requests and paces charge go pulses with tune+gap timing
// TUNE_SCHED_FLUSH_EN enables the pending-queue flush input.
module tune_scheduler #(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [25:0] TUNE_CLKS = 26'd58720272,
  parameter logic [25:0] GAP_CLKS  = 26'd1048576,
  parameter int          PEND_W    = 3
) (
  input logic         clk,
  input logic         rst_n,
  tune_sched_if.slave bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [25:0]       DEC      = FAST_SIM ? 26'd16 : 26'd1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e            state_q, state_d;
  logic [25:0]       timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              go_q, go_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              drop;
  logic              flush;
  logic [25:0]       timer_dec;

`ifdef TUNE_SCHED_FLUSH_EN
  assign flush = bus.flush;
`else
  assign flush = 1'b0;
`endif

  // Saturating decrement: the timer never wraps below zero.
  assign timer_dec = (timer_q < DEC) ? '0 : timer_q - DEC;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    go_d    = 1'b0;
    ovf_d   = ovf_q;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req || pend_q != '0) begin
          state_d = PLAY;
          go_d    = 1'b1;
          timer_d = TUNE_CLKS;
        end
      end
      PLAY: begin
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_CLKS;
        end else begin
          timer_d = timer_dec;
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_dec;
      end
      default: state_d = IDLE;
    endcase

    // A go in the same clk as a req nets to zero change, whichever source feeds it.
    if (go_d) begin
      if (pend_q != '0 && !bus.req) pend_d = pend_q - PEND_ONE;
    end else if (bus.req) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end

    if (flush) pend_d = '0;

    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.go       = go_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_tune_scheduler.sv
// tb/tb_tune_scheduler.sv - randomized bench for tune_scheduler against a timeline model
module tb_tune_scheduler;
  localparam int TUNE = 64;
  localparam int GAP  = 32;
  localparam int PW   = 3;
  localparam int MAXP = 7;
`ifdef TUNE_SCHED_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tune_sched_if #(.PEND_W(PW)) bus ();

  tune_scheduler #(
    .FAST_SIM (1'b0),
    .TUNE_CLKS(26'd64),
    .GAP_CLKS (26'd32),
    .PEND_W   (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;
  int idle_at = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  bit exp_go = 1'b0;
  bit exp_busy = 1'b0;
  int exp_pend = 0;
  bit exp_ovf = 1'b0;
  bit chk_en = 1'b0;
  int go_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("go", 32'(bus.go), 32'(exp_go));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("pending", 32'(bus.pending), exp_pend);
      check("overflow", 32'(bus.overflow), 32'(exp_ovf));
      if (bus.go === 1'b1) go_log.push_back(cyc + 1);
    end
  end

  // Model: a go at cycle t keeps the block busy through t+TUNE+GAP+2.
  task automatic step(input bit r, input bit c, input bit f);
    bit go;
    bit drop;
    @(posedge clk);
    #2;
    cyc++;
    bus.req = r;
    bus.ovf_clr = c;
`ifdef TUNE_SCHED_FLUSH_EN
    bus.flush = f;
`endif
    go = (cyc >= idle_at) && (r || m_pend > 0);
    drop = 1'b0;
    if (go) begin
      idle_at = cyc + TUNE + GAP + 3;
      if (m_pend > 0 && !r) m_pend--;
    end else if (r) begin
      if (m_pend == MAXP) drop = 1'b1;
      else m_pend++;
    end
    if (f) m_pend = 0;
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    exp_go = go;
    exp_busy = (cyc + 1 < idle_at);
    exp_pend = m_pend;
    exp_ovf = m_ovf;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.ovf_clr = 1'b0;
`ifdef TUNE_SCHED_FLUSH_EN
    bus.flush = 1'b0;
`endif
    #1;
    check("rst_go", 32'(bus.go), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    @(posedge clk);
    #1;
    check("rst_go_held", 32'(bus.go), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    idle_at = 0;
    m_pend = 0;
    m_ovf = 1'b0;
    exp_go = 1'b0;
    exp_busy = 1'b0;
    exp_pend = 0;
    exp_ovf = 1'b0;
    go_log.delete();
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, c, f;
    int p;
    bus.req = 1'b0;
    bus.ovf_clr = 1'b0;
`ifdef TUNE_SCHED_FLUSH_EN
    bus.flush = 1'b0;
`endif

    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("idle_go_count", go_log.size(), 0);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 11; i <= 320; i++) begin
      step(i == 20 || i == 30 || i == 40, 1'b0, 1'b0);
      if (cyc == 50)  check("pend_queued3", 32'(bus.pending), 3);
      if (cyc == 108) check("busy_last", 32'(bus.busy), 1);
      if (cyc == 109) check("busy_idle_gap", 32'(bus.busy), 0);
    end
    check("go_count", go_log.size(), 4);
    if (go_log.size() == 4) begin
      check("go_t0", go_log[0], 11);
      check("go_t1", go_log[1], 110);
      check("go_t2", go_log[2], 209);
      check("go_t3", go_log[3], 308);
    end
    check("pend_drained", 32'(bus.pending), 0);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pend_sat", 32'(bus.pending), 7);
    check("ovf_set", 32'(bus.overflow), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_cleared", 32'(bus.overflow), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_set_wins", 32'(bus.overflow), 1);
    check("busy_before_rst", 32'(bus.busy), 1);
    do_reset();

    if (HAS_FLUSH) begin
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("pend_pre_flush", 32'(bus.pending), 4);
      step(1'b0, 1'b0, 1'b0);
      check("pend_flushed", 32'(bus.pending), 0);
      check("busy_after_flush", 32'(bus.busy), 1);
      for (int i = 0; i < 110; i++) step(1'b0, 1'b0, 1'b0);
      check("flush_go_count", go_log.size(), 1);
    end

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      p = ((i / 1000) % 2 == 1) ? 2 : 25;
      r = ($urandom_range(p - 1) == 0);
      c = ($urandom_range(39) == 0);
      f = HAS_FLUSH && ($urandom_range(99) == 0);
      if ($urandom_range(1499) == 0) do_reset();
      else step(r, c, f);
    end
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
